// File: rtl/pkt_sched_pkg.sv
// Shared types and helpers for the packet weighted round-robin scheduler.
//   sched_state_e : scheduler FSM states (IDLE arbitrate, XFER transfer).
//   AVL_DATA_W    : default Avalon-ST data width.
//   AVL_EMPTY_W   : default empty-field width, log2(AVL_DATA_W/8).
//   rr_pick()     : rotating-priority search over up to MAX_IN requesters.
package pkt_sched_pkg;

  typedef enum logic [0:0] {IDLE, XFER} sched_state_e;

  localparam int unsigned AVL_DATA_W  = 512;
  localparam int unsigned AVL_EMPTY_W = 6;
  localparam int unsigned MAX_IN      = 8;
  localparam int unsigned PTR_W       = 3;

  // Returns the first set bit of eligible at or after ptr, wrapping modulo num_in.
  // With no set bit the result is ptr; callers qualify it with |eligible.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_IN-1:0] eligible,
                                              input logic [PTR_W-1:0]  ptr,
                                              input int unsigned       num_in);
    logic [PTR_W-1:0] idx;
    logic             found;
    int unsigned      j;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_IN; k++) begin
      if (!found && k < num_in) begin
        j = (32'(ptr) + k) % num_in;
        if (eligible[j[PTR_W-1:0]]) begin
          idx   = j[PTR_W-1:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_ptr.sv
// Rotating-priority arbiter with registered round-robin pointer.
//   clk_i, rst_ni : clock, synchronous active-low reset (pointer clears to 0).
//   eligible_i    : per-input request vector.
//   advance_i     : end of the current turn; pointer moves past last_i.
//   last_i        : index of the input whose turn is ending.
//   pick_o, hit_o : search result starting at the pointer, and any-request flag.
module rr_arb_ptr
  import pkt_sched_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned CH_W   = $clog2(NUM_IN)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_IN-1:0] eligible_i,
  input  logic              advance_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   pick_o,
  output logic              hit_o
);

  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0] pick_full;

  assign pick_full = rr_pick(MAX_IN'(eligible_i), PTR_W'(ptr_q), NUM_IN);
  assign pick_o    = CH_W'(pick_full);
  assign hit_o     = |eligible_i;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (last_i == CH_W'(NUM_IN - 1)) ? '0 : last_i + CH_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pkt_wrr_sched_avlstrm.sv
// Packet-atomic weighted round-robin scheduler merging NUM_IN Avalon-ST sources
// onto one registered egress stream. Grants move only on packet boundaries; each
// input may send cfg_weight packets per turn (0 disables it).
//   Clk, Rst_n        : clock, synchronous active-low reset.
//   in_*              : per-input Avalon-ST sinks, input i in slice i.
//   cfg_weight        : packets per turn for each input.
//   out_*             : registered Avalon-ST source; out_channel names the input.
// Optional macro PKT_WRR_SCHED_STATS_EN adds stat_pkt_cnt (per-input eop count,
// wrapping) and stat_stall_cnt (out_valid && !out_ready cycles, saturating).
module pkt_wrr_sched_avlstrm
  import pkt_sched_pkg::*;
#(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned DATA_W   = AVL_DATA_W,
  parameter int unsigned EMPTY_W  = AVL_EMPTY_W,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned CH_W     = $clog2(NUM_IN)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]          in_sop,
  input  logic [NUM_IN-1:0]          in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0]  in_empty,
  input  logic [NUM_IN*WEIGHT_W-1:0] cfg_weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [CH_W-1:0]            out_channel
`ifdef PKT_WRR_SCHED_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]       stat_pkt_cnt,
  output logic [31:0]                stat_stall_cnt
`endif
);

  sched_state_e        state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d, credit_dec;
  // Set between an eop that keeps the turn and the next accepted beat.
  logic                boundary_q, boundary_d;

  logic [WEIGHT_W-1:0] weight    [NUM_IN];
  logic [DATA_W-1:0]   data_arr  [NUM_IN];
  logic [EMPTY_W-1:0]  empty_arr [NUM_IN];
  logic [NUM_IN-1:0]   eligible;
  logic [CH_W-1:0]     pick;
  logic                hit, advance, accept, acc_eop;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign weight[i]    = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
    assign data_arr[i]  = in_data[i*DATA_W +: DATA_W];
    assign empty_arr[i] = in_empty[i*EMPTY_W +: EMPTY_W];
    assign eligible[i]  = in_valid[i] && in_sop[i] && (weight[i] != '0);
  end

  rr_arb_ptr #(
    .NUM_IN (NUM_IN),
    .CH_W   (CH_W)
  ) u_arb (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .eligible_i (eligible),
    .advance_i  (advance),
    .last_i     (grant_q),
    .pick_o     (pick),
    .hit_o      (hit)
  );

  assign accept     = (state_q == XFER) && in_valid[grant_q] && in_ready[grant_q];
  assign acc_eop    = accept && in_eop[grant_q];
  assign credit_dec = credit_q - WEIGHT_W'(1);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      credit_q   <= '0;
      boundary_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      credit_q   <= credit_d;
      boundary_q <= boundary_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    credit_d   = credit_q;
    boundary_d = boundary_q;
    advance    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          grant_d    = pick;
          credit_d   = weight[pick];
          boundary_d = 1'b0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          boundary_d = 1'b0;
          if (in_eop[grant_q]) begin
            credit_d = credit_dec;
            if (credit_dec == '0 || weight[grant_q] == '0) begin
              advance = 1'b1;
              state_d = IDLE;
            end else begin
              boundary_d = 1'b1;
            end
          end
        end else if (boundary_q && !in_valid[grant_q]) begin
          // Source has nothing queued after its eop: give up the rest of the turn.
          advance    = 1'b1;
          boundary_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state_q == XFER) begin
      in_ready[grant_q] = !out_valid || out_ready;
    end
  end

  // Output stage: load on accept, drop valid once taken, otherwise hold.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
      out_channel <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= data_arr[grant_q];
      out_sop     <= in_sop[grant_q];
      out_eop     <= in_eop[grant_q];
      out_empty   <= empty_arr[grant_q];
      out_channel <= grant_q;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef PKT_WRR_SCHED_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_IN];

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        pkt_cnt_q[i] <= '0;
      end
      stat_stall_cnt <= '0;
    end else begin
      if (acc_eop) begin
        pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
      end
      if (out_valid && !out_ready && stat_stall_cnt != '1) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_stat
    assign stat_pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_pkt_wrr_sched_avlstrm.sv
// Scoreboard bench for pkt_wrr_sched_avlstrm: per-input source queues drive the
// DUT, tests push expected egress beats, a monitor pops and compares each beat.
module tb_pkt_wrr_sched_avlstrm;
  import pkt_sched_pkg::*;

  localparam int NI = 4;
  localparam int DW = 512;
  localparam int EW = 6;
  localparam int WW = 4;
  localparam int CW = 2;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [NI-1:0]    in_valid, in_ready, in_sop, in_eop;
  logic [NI*DW-1:0] in_data;
  logic [NI*EW-1:0] in_empty;
  logic [NI*WW-1:0] cfg_weight;
  logic             out_valid, out_ready, out_sop, out_eop;
  logic [DW-1:0]    out_data;
  logic [EW-1:0]    out_empty;
  logic [CW-1:0]    out_channel;
`ifdef PKT_WRR_SCHED_STATS_EN
  logic [NI*32-1:0] stat_pkt_cnt;
  logic [31:0]      stat_stall_cnt;
`endif

  always #5 Clk = ~Clk;

  pkt_wrr_sched_avlstrm dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_empty    (in_empty),
    .cfg_weight  (cfg_weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_empty   (out_empty),
    .out_channel (out_channel)
`ifdef PKT_WRR_SCHED_STATS_EN
    ,
    .stat_pkt_cnt   (stat_pkt_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    int            ch;
  } beat_t;

  beat_t src_q [NI][$];
  beat_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int hold_cnt = 0;
  bit flush_req = 1'b0;
  bit mon_in2 = 1'b0;
  bit in2_seen = 1'b0;

  function automatic beat_t mk(input int ch, input int pkt, input int b, input int nb);
    beat_t x;
    x.data  = {16{8'hA5, 8'(ch), 8'(pkt), 8'(b)}};
    x.sop   = (b == 0);
    x.eop   = (b == nb - 1);
    x.empty = x.eop ? EW'(ch * 8 + pkt + 1) : '0;
    x.ch    = ch;
    return x;
  endfunction

  task automatic load_pkt(input int ch, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) src_q[ch].push_back(mk(ch, pkt, b, nb));
  endtask

  task automatic expect_pkt(input int ch, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) exp_q.push_back(mk(ch, pkt, b, nb));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i]              = 1'b1;
        in_data[i*DW +: DW]      = src_q[i][0].data;
        in_sop[i]                = src_q[i][0].sop;
        in_eop[i]                = src_q[i][0].eop;
        in_empty[i*EW +: EW]     = src_q[i][0].empty;
      end else begin
        in_valid[i]              = 1'b0;
        in_data[i*DW +: DW]      = '0;
        in_sop[i]                = 1'b0;
        in_eop[i]                = 1'b0;
        in_empty[i*EW +: EW]     = '0;
      end
    end
  endtask

  // Sources: handshake sampled mid-cycle, queue advanced just after the edge.
  initial begin
    logic [NI-1:0] fire;
    drive_inputs();
    forever begin
      @(negedge Clk);
      fire = in_valid & in_ready;
      @(posedge Clk);
      #1;
      if (flush_req) begin
        for (int i = 0; i < NI; i++) src_q[i].delete();
        flush_req = 1'b0;
      end else begin
        for (int i = 0; i < NI; i++)
          if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      drive_inputs();
    end
  end

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Monitor: compare egress beats against the scoreboard and check holding.
  initial begin
    beat_t e;
    beat_t snap;
    bit    held;
    held = 1'b0;
    forever begin
      @(negedge Clk);
      if (held) begin
        checks++;
        if (!out_valid || out_data !== snap.data || out_sop !== snap.sop ||
            out_eop !== snap.eop || out_empty !== snap.empty || out_channel !== CW'(snap.ch)) begin
          errors++;
          $display("FAIL hold: got v=%0b ch=%0d d=%0h, expected held ch=%0d d=%0h",
                   out_valid, out_channel, out_data[31:0], snap.ch, snap.data[31:0]);
        end
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got unexpected ch=%0d d=%0h, expected no beat",
                     out_channel, out_data[31:0]);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop ||
                out_empty !== e.empty || out_channel !== CW'(e.ch)) begin
              errors++;
              $display("FAIL beat: got ch=%0d d=%0h s=%0b e=%0b em=%0d, expected ch=%0d d=%0h s=%0b e=%0b em=%0d",
                       out_channel, out_data[31:0], out_sop, out_eop, out_empty,
                       e.ch, e.data[31:0], e.sop, e.eop, e.empty);
            end
            beat_cnt++;
            if (beat_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
          end
        end else begin
          held = 1'b1;
          hold_cnt++;
          snap.data  = out_data;
          snap.sop   = out_sop;
          snap.eop   = out_eop;
          snap.empty = out_empty;
          snap.ch    = int'(out_channel);
        end
      end
      if (mon_in2 && in_ready[2]) in2_seen = 1'b1;
    end
  end

  task automatic do_reset();
    Rst_n = 1'b0;
    flush_req = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge Clk);
      n++;
    end
    repeat (4) @(posedge Clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d beats outstanding, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    out_ready  = 1'b1;
    cfg_weight = '0;
    repeat (3) @(posedge Clk);
    #2;

    // All weights 1, 3-beat packets: 0,1,2,3 order, one bubble per grant.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    beat_cnt = 0;
    for (int p = 0; p < 2; p++)
      for (int ch = 0; ch < NI; ch++) begin
        load_pkt(ch, p, 3);
        expect_pkt(ch, p, 3);
      end
    wait_drain("rr_w1", 200);
    check("rr_w1_beats", 64'(beat_cnt), 64'd24);
    check("rr_w1_span", 64'(last_cyc - first_cyc), 64'd30);

    // Reset state after a busy test.
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data[63:0]), 64'd0);
    check("rst_out_channel", 64'(out_channel), 64'd0);
    check("rst_out_flags", {61'd0, out_sop, out_eop, 1'b0} | 64'(out_empty), 64'd0);

    // Weights {3,1,0,2}, single-beat backlog: 0,0,0,1,3,3 repeating; input 2 starved.
    cfg_weight = {4'd2, 4'd0, 4'd1, 4'd3};
    mon_in2 = 1'b1;
    in2_seen = 1'b0;
    for (int p = 0; p < 6; p++) load_pkt(0, p, 1);
    for (int p = 0; p < 2; p++) load_pkt(1, p, 1);
    for (int p = 0; p < 2; p++) load_pkt(2, p, 1);
    for (int p = 0; p < 4; p++) load_pkt(3, p, 1);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) expect_pkt(0, r * 3 + p, 1);
      expect_pkt(1, r, 1);
      for (int p = 0; p < 2; p++) expect_pkt(3, r * 2 + p, 1);
    end
    wait_drain("wrr", 200);
    mon_in2 = 1'b0;
    check("wrr_in2_ready", 64'(in2_seen), 64'd0);

    // out_ready toggling during a 4-beat packet from input 1.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    hold_cnt = 0;
    load_pkt(1, 0, 4);
    expect_pkt(1, 0, 4);
    for (int k = 0; k < 16; k++) begin
      @(posedge Clk);
      #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_drain("toggle", 100);
    check("toggle_hold_seen", 64'(hold_cnt > 0), 64'd1);

    // Weight 4 on input 0, source runs dry after 2 packets: grant moves on.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd4};
    load_pkt(0, 0, 2);
    load_pkt(0, 1, 2);
    load_pkt(2, 0, 1);
    load_pkt(3, 0, 1);
    expect_pkt(0, 0, 2);
    expect_pkt(0, 1, 2);
    expect_pkt(2, 0, 1);
    expect_pkt(3, 0, 1);
    n = 0;
    while (!(dut.state_q == XFER && dut.grant_q == 2'd2) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("drop_grant2_reached", 64'(n < 100), 64'd1);
    check("drop_rr_ptr", 64'(dut.u_arb.ptr_q), 64'd1);
    wait_drain("drop", 100);

    // Reset mid-packet: no further beats, arbitration restarts at input 0.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    beat_cnt = 0;
    load_pkt(1, 0, 1);
    expect_pkt(1, 0, 1);
    load_pkt(2, 0, 5);
    exp_q.push_back(mk(2, 0, 0, 5));
    exp_q.push_back(mk(2, 0, 1, 5));
    n = 0;
    while (beat_cnt < 3 && n < 200) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check("midrst_trigger", 64'(beat_cnt), 64'd3);
    Rst_n = 1'b0;
    flush_req = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_state_idle", 64'(dut.state_q == IDLE), 64'd1);
    Rst_n = 1'b1;
    #1;
    for (int ch = 0; ch < NI; ch++) begin
      load_pkt(ch, 1, 1);
      expect_pkt(ch, 1, 1);
    end
    wait_drain("midrst", 200);

`ifdef PKT_WRR_SCHED_STATS_EN
    // 10 packets on input 2 with a 7-cycle egress stall.
    do_reset();
    cfg_weight = {4'd1, 4'd10, 4'd1, 4'd1};
    out_ready = 1'b0;
    for (int p = 0; p < 10; p++) begin
      load_pkt(2, p, 1);
      expect_pkt(2, p, 1);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    repeat (7) @(posedge Clk);
    #1;
    out_ready = 1'b1;
    wait_drain("stats", 200);
    check("stat_pkt_cnt2", 64'(stat_pkt_cnt[2*32 +: 32]), 64'd10);
    check("stat_stall_cnt", 64'(stat_stall_cnt), 64'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_wrr_sched_avlstrm.md
Name: pkt_wrr_sched_avlstrm

Overview:
- Packet-atomic weighted round-robin scheduler that shares one 512-bit Avalon-ST egress stream among NUM_IN packet sources.
- Used wherever several pipeline outputs converge onto one Ethernet or DMA path, for example the egress merge ahead of the MAC TX.
- Grants change only on packet boundaries.
- A per-input weight sets how many whole packets an input may send per round-robin turn.
- The output is registered, so the block also acts as a pipeline stage.

Parameters:
- NUM_IN, 4: number of requesting input streams, range 2..8.
- DATA_W, 512: data width in bits.
- EMPTY_W, 6: width of the empty field, equal to log2(DATA_W/8).
- WEIGHT_W, 4: width of each per-input weight.
- CH_W, $clog2(NUM_IN): width of the output channel index.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  synchronous active-low reset.
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready.
- in_data  in  NUM_IN*DATA_W  input data; input i occupies slice i.
- in_sop  in  NUM_IN  start of packet.
- in_eop  in  NUM_IN  end of packet.
- in_empty  in  NUM_IN*EMPTY_W  empty bytes on the eop beat.
- cfg_weight  in  NUM_IN*WEIGHT_W  packets per turn for each input; 0 disables that input.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- out_data  out  DATA_W  output data.
- out_sop  out  1  output start of packet.
- out_eop  out  1  output end of packet.
- out_empty  out  EMPTY_W  output empty bytes.
- out_channel  out  CH_W  index of the input that sourced the beat.

Behaviour:
- Reset (Rst_n=0 sampled at a rising Clk edge):
  - state=IDLE, rr_ptr=0, credit=0.
  - out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, out_channel=0, in_ready=0.
  - A packet in flight is abandoned. No output beat is produced after reset is sampled.
- State IDLE:
  - eligible[i] = in_valid[i] && in_sop[i] && cfg_weight[i]!=0.
  - A beat with in_valid=1 and sop=0 on a non-granted input is left pending, never consumed.
  - Search eligible inputs starting at rr_ptr and wrapping modulo NUM_IN. The first hit is g.
  - Load credit=cfg_weight[g] and go to XFER, all in one cycle. Nothing transfers in the IDLE cycle.
  - If there is no hit, stay in IDLE.
- State XFER:
  - in_ready[g] = !out_valid || out_ready. All other in_ready bits are 0.
  - When in_valid[g] && in_ready[g], register the beat into the output: out_* take in_*[g], out_channel=g, out_valid=1.
  - Otherwise, if out_ready, then out_valid becomes 0.
- End of packet (accepted beat with eop=1; a single-beat sop+eop packet counts):
  - credit decrements by 1.
  - If the new credit is 0, or !in_valid[g], or cfg_weight[g]==0: rr_ptr=(g+1) mod NUM_IN and go to IDLE.
  - Otherwise stay in XFER on g for the next packet. That packet must start with sop. A non-sop first beat is passed through unchanged; the block does not check framing.
- Latency and throughput:
  - One cycle from input acceptance to out_valid.
  - Full throughput within a packet and within back-to-back packets of the same grant.
  - One bubble cycle on each grant change (the IDLE arbitration cycle).
- Output holding: out_* stay stable while out_valid && !out_ready, as required by Avalon-ST.
- Weight changes: a new cfg_weight is sampled only when credit reloads in IDLE. A weight set to 0 mid-turn ends the turn at the next eop.
- Credit is WEIGHT_W bits wide and never underflows, because it is only decremented on an eop and is always at least 1 in XFER.

Optional Feature:
- Macro: PKT_WRR_SCHED_STATS_EN.
- When defined:
  - Adds output port stat_pkt_cnt, NUM_IN*32 bits.
  - Each counter counts accepted eop beats for its input.
  - Counters wrap from 2^32-1 to 0 and clear on reset.
  - Adds output port stat_stall_cnt, 32 bits, which increments every cycle with out_valid && !out_ready and saturates at 2^32-1.
- When undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package pkt_sched_pkg: sched_state_e {IDLE, XFER}, localparam AVL_DATA_W=512, AVL_EMPTY_W=6, and a function rr_pick(eligible, ptr) that returns the index.
- One natural sub-module, rr_arb_ptr: the combinational rotating-priority search plus the registered rr_ptr.
- The top level holds the FSM, the credit counter and the output register stage.

Test Plan:
- All weights 1, NUM_IN=4, every input streaming 3-beat packets, out_ready=1:
  - Channel order is 0,1,2,3,0…
  - Each grant change adds one bubble: 4 beats per 3 data beats.
  - No interleaving within a packet.
- Weights {3,1,0,2}, all inputs backlogged with single-beat packets:
  - Channel sequence is 0,0,0,1,3,3 repeating.
  - Input 2 is never granted and in_ready[2] stays 0.
- out_ready toggles 1010… during a 4-beat packet from input 1:
  - The output beats are held stable when not ready.
  - No beat is lost or duplicated.
  - Data order is preserved.
- Weight 4 on input 0, but its source drops in_valid after 2 packets:
  - The grant moves to the next eligible input.
  - rr_ptr=1.
- Rst_n driven low for 1 cycle on beat 2 of a 5-beat packet:
  - The next cycle shows out_valid=0, in_ready=0, state IDLE.
  - After release, arbitration restarts at input 0.
- With PKT_WRR_SCHED_STATS_EN defined, 10 packets sent on input 2 and out_ready held low for 7 cycles:
  - stat_pkt_cnt[2]=10.
  - stat_stall_cnt=7.
